// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl
//   SPI initiator that sends one 11-bit frame per host command:
//   {cmd[1], cmd[1], cmd[0], wdata}, MSB first, one bit per clk cycle.
//   For read-data (cmd==2'b11) it waits TURNAROUND cycles and then shifts in
//   DATA_W response bits from MISO.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   start          host request (taken only when idle)
//   cmd, wdata     opcode and payload, latched at accept
//   abort          end the current frame early (SEND/WAIT/RECV only)
//   busy           high from accept until back in IDLE
//   done, aborted  frame-end pulse and its abort qualifier
//   rd_data        last completed read-data response
//   SS_n, MOSI     slave select (active low) and serial data out
//   MISO           serial data in
module spi_master_ctrl #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned TURNAROUND = 2,
  parameter int unsigned IDLE_CYC   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        cmd,
  input  logic [DATA_W-1:0] wdata,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [DATA_W-1:0] rd_data,
  output logic              SS_n,
  output logic              MOSI,
  input  logic              MISO
);

  localparam int unsigned FRAME_W = DATA_W + 3;

  // Terminal counts for the shared 4-bit counter in each timed state.
  localparam logic [3:0] SEND_LAST = 4'(FRAME_W - 1);
  localparam logic [3:0] WAIT_LAST = 4'(TURNAROUND - 1);
  localparam logic [3:0] RECV_LAST = 4'(DATA_W - 1);
  localparam logic [3:0] GAP_LAST  = 4'(IDLE_CYC - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_RECV,
    S_END,
    S_GAP
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [1:0]          cmd_q, cmd_d;
  logic [FRAME_W-1:0]  frame_q, frame_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                ss_n_q, ss_n_d;
  logic                mosi_q, mosi_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                aborted_q, aborted_d;

  logic                accept;
  logic                abort_hit;
  logic                rd_load;
  logic [3:0]          cnt_inc;

  assign cnt_inc = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      cmd_q     <= '0;
      frame_q   <= '0;
      shreg_q   <= '0;
      rd_data_q <= '0;
      ss_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cmd_q     <= cmd_d;
      frame_q   <= frame_d;
      shreg_q   <= shreg_d;
      rd_data_q <= rd_data_d;
      ss_n_q    <= ss_n_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cmd_d     = cmd_q;
    frame_d   = frame_q;
    shreg_d   = shreg_q;
    accept    = 1'b0;
    abort_hit = 1'b0;
    rd_load   = 1'b0;

    case (state_q)
      S_IDLE: begin
        accept = start;
      end
      S_SEND: begin
        if (abort) begin
          state_d   = S_END;
          abort_hit = 1'b1;
        end else if (cnt_q == SEND_LAST) begin
          cnt_d = '0;
          if (cmd_q == 2'b11) begin
            state_d = (TURNAROUND == 0) ? S_RECV : S_WAIT;
          end else begin
            state_d = S_END;
          end
        end else begin
          cnt_d   = cnt_inc;
          frame_d = frame_q << 1;
        end
      end
      S_WAIT: begin
        if (abort) begin
          state_d   = S_END;
          abort_hit = 1'b1;
        end else if (cnt_q == WAIT_LAST) begin
          state_d = S_RECV;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_RECV: begin
        if (abort) begin
          state_d   = S_END;
          abort_hit = 1'b1;
        end else begin
          shreg_d = {shreg_q[DATA_W-2:0], MISO};
          if (cnt_q == RECV_LAST) begin
            state_d = S_END;
            rd_load = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      S_END: begin
        cnt_d = '0;
        if (IDLE_CYC <= 1) begin
          state_d = S_IDLE;
          accept  = start;
        end else begin
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          accept  = start;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // A start seen on the edge that would enter IDLE is taken right away,
    // so a held start leaves SS_n high for exactly IDLE_CYC cycles.
    if (accept) begin
      state_d = S_SEND;
      cnt_d   = '0;
      cmd_d   = cmd;
      frame_d = {cmd[1], cmd, wdata};
    end
  end

  // Registered outputs are computed from the upcoming state.
  always_comb begin
    ss_n_d    = !(state_d == S_SEND || state_d == S_WAIT || state_d == S_RECV);
    mosi_d    = (state_d == S_SEND) ? frame_d[FRAME_W-1] : 1'b0;
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_END);
    aborted_d = abort_hit;
    rd_data_d = rd_load ? shreg_d : rd_data_q;
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign aborted = aborted_q;
  assign rd_data = rd_data_q;
  assign SS_n    = ss_n_q;
  assign MOSI    = mosi_q;

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
- Single-clock SPI initiator that drives the far end of our SPI slave wrapper (MOSI/SS_n out, MISO in).
- Takes one host command per transaction and serialises a 10-bit command word (2-bit opcode + 8-bit payload) on MOSI.
- For read-data opcodes it also collects the 8-bit response from MISO.
- Sits between the bench/host sequencer and the SPI wrapper. The SPI bit clock is clk itself: one bit per clk cycle.

Parameters:
- DATA_W, 8, payload and read-response width in bits.
- TURNAROUND, 2, clk cycles between the last MOSI bit and the first MISO sample on read-data frames (range 0..15).
- IDLE_CYC, 1, minimum clk cycles SS_n stays high between frames (range 1..15).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  host request; accepted only when busy==0.
- cmd  in  2  opcode: 00 write-addr, 01 write-data, 10 read-addr, 11 read-data.
- wdata  in  DATA_W  payload (address, write data, or don't-care for 11).
- abort  in  1  terminate the current frame early.
- busy  out  1  high from the accept cycle until back in IDLE.
- done  out  1  one-cycle pulse at frame end.
- aborted  out  1  qualifies done; high if the frame was aborted.
- rd_data  out  DATA_W  last read response; held until the next completed read-data frame.
- SS_n  out  1  slave select, active low.
- MOSI  out  1  serial data to the slave.
- MISO  in  1  serial data from the slave.

Behaviour:
- All outputs are registered.
- Reset values: SS_n=1, MOSI=0, busy=0, done=0, aborted=0, rd_data=0. State is IDLE and all counters are 0.
- Frame bit order on MOSI is 11 bits: cmd[1], cmd[1], cmd[0], wdata[7]..wdata[0]. MSB first; the leading bit is the slave's read/write select.
- States: IDLE, SEND, WAIT, RECV, END, GAP.
- IDLE → SEND: when start==1 at edge T.
  - Latch cmd and wdata; busy=1.
  - From T+1: SS_n=0, MOSI=bit0.
  - start while busy is ignored and not queued.
- SEND: presents MOSI bit k during cycle T+1+k, k=0..10 (11 cycles).
  - After bit 10, cmd==11 goes to WAIT; any other cmd goes to END.
- WAIT: holds SS_n=0 and MOSI=0 for TURNAROUND cycles. TURNAROUND==0 goes straight to RECV.
- RECV: 8 cycles.
  - Each rising edge shifts MISO into a shift register, MSB first.
  - After the 8th sample go to END. rd_data gets the shift register on entry to END.
- END: one cycle with SS_n=1, MOSI=0, done=1.
  - Then GAP for IDLE_CYC-1 cycles, or IDLE if IDLE_CYC==1.
  - busy=0 in IDLE.
- Latency:
  - Non-read-data frame: SS_n low for exactly 11 cycles; done at T+12.
  - Read-data frame: SS_n low for 11+TURNAROUND+8 cycles; done at T+12+TURNAROUND+8.
- Back-to-back: start held high re-accepts in the first IDLE cycle. SS_n is therefore high for at least IDLE_CYC cycles.
- abort==1 in SEND, WAIT or RECV: the next cycle is END with done=1 and aborted=1.
  - rd_data is NOT updated.
  - abort in IDLE, END or GAP is ignored.
  - abort and start in the same IDLE cycle: start wins.
- rst mid-frame: the next edge forces SS_n=1 and state IDLE. No done pulse is emitted, and rd_data is cleared to 0.
- Bit counter is 4 bits and saturates. It never wraps inside a frame.

Test Plan:
- Write-addr: cmd=00, wdata=8'hA5 → SS_n low T+1..T+11; MOSI=0,0,0,1,0,1,0,0,1,0,1; done at T+12, aborted=0.
- Read-data with TURNAROUND=2: cmd=11, slave model drives MISO=8'h3C starting at cycle T+14 → SS_n low 21 cycles; rd_data=8'h3C at the done pulse (T+22).
- Back-to-back with IDLE_CYC=3: start held high → SS_n high for exactly 3 cycles between frames; the second frame's opcode is taken from cmd at its accept edge.
- Abort in RECV after 4 samples → SS_n high next cycle; done=1, aborted=1; rd_data keeps its previous value.
- rst asserted in SEND cycle 5 → next edge SS_n=1, busy=0, rd_data=0, no done pulse. A start after rst is released produces a normal full frame.
- Full loop against the SPI wrapper: write-addr 8'h10, write-data 8'h77, read-addr 8'h10, read-data → rd_data=8'h77. The wrapper's rx_valid rises once per frame, 10 bits after its command check.
